ctech_lib_and_en_ctrl: RTL

- Sequential enable controller that drives the enable (b) leg of a ctech AND gating cell. The gated path is data or a clock-qualifier: o = a & gate_en.
- Sits on the requester side of that gate. Turns a level request plus activity hints into a glitch-free registered gate_en, with a wake settling window, an idle-drain hold-off, and an en_req/en_ack handshake back to the requester.

---
 rtl/ctech_lib_and_en_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/ctech_lib_and_en_ctrl.sv
// Registered enable controller for the b leg of a ctech AND gating cell (o = a & gate_en).
// Optional saturating on-time counter output on_cnt when CTECH_LIB_AND_EN_CTRL_STATUS_EN is defined.
//
// state | meaning
// OFF   | gate_en low, waiting for any activity
// WAKE  | gate_en high, gated path settling for WAKE_CYC cycles
// ON    | gate_en high, en_ack high, path usable
// DRAIN | gate_en high, counting IDLE_CYC idle cycles before release
module ctech_lib_and_en_ctrl #(
  parameter int CW       = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_req,
  input  logic        busy,
  input  logic        force_on,
  output logic        gate_en,
  output logic        en_ack,
`ifdef CTECH_LIB_AND_EN_CTRL_STATUS_EN
  output logic [1:0]  st,
  output logic [15:0] on_cnt
`else
  output logic [1:0]  st
`endif
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_WAKE  = 2'b01,
    S_ON    = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC > 0 ? WAKE_CYC - 1 : 0);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC > 0 ? IDLE_CYC - 1 : 0);

  if (CW < 1 || CW > 16) begin : g_bad_cw
    $error("ctech_lib_and_en_ctrl: CW must be 1..16");
  end
  if (WAKE_CYC < 0 || WAKE_CYC > (2 ** CW) - 1) begin : g_bad_wake
    $error("ctech_lib_and_en_ctrl: WAKE_CYC out of range 0..2^CW-1");
  end
  if (IDLE_CYC < 1 || IDLE_CYC > (2 ** CW) - 1) begin : g_bad_idle
    $error("ctech_lib_and_en_ctrl: IDLE_CYC out of range 1..2^CW-1");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act;

  assign act = en_req | busy | force_on;
  assign st  = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (act) begin
          if (WAKE_CYC > 0) begin
            state_d = S_WAKE;
            cnt_d   = WAKE_LD;
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_WAKE: begin
        // wake runs to completion regardless of act
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = S_ON;
      end
      S_ON: begin
        if (!act) begin
          state_d = S_DRAIN;
          cnt_d   = IDLE_LD;
        end
      end
      S_DRAIN: begin
        if (act)               state_d = S_ON;
        else if (cnt_q == '0)  state_d = S_OFF;
        else                   cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs are registered from the next state so they line up with st
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      gate_en <= 1'b0;
      en_ack  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_en <= (state_d != S_OFF);
      en_ack  <= (state_d == S_ON);
    end
  end

`ifdef CTECH_LIB_AND_EN_CTRL_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst)                              on_cnt <= '0;
    else if (gate_en && on_cnt != 16'hFFFF) on_cnt <= on_cnt + 16'd1;
  end
`endif

endmodule
